multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-003 Opcode  input  6  instruction bits [31:26], taken from the instruction register.
REQ-004 Funct  input  6  instruction bits [5:0].
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 MWE  output  1  memory write enable to the unified word-addressed memory.
REQ-007 IorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-008 IRWrite  output  1  instruction register load.
REQ-009 RFWE  output  1  register file write enable.
REQ-010 RegDst  output  1  write register select: 0=rt, 1=rd.
REQ-011 MtoRF  output  1  write data select: 0=ALUOut, 1=MDR.
REQ-012 ALUSrcA  output  1  0=PC, 1=register A.
REQ-013 ALUSrcB  output  2  00=B, 01=constant 1, 10=SignImm, 11=reserved (drive SignImm).
REQ-014 ALUSel  output  4  0000 ADD, 0001 SUB, 0010 SLL(shamt), 0011 SLLV, 0100 SRAV.
REQ-015 PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target.
REQ-016 PCEn  output  1  PC load = PCWrite | (Branch & Zero).
REQ-017 State  output  4  current state code (debug and verification).

Function
REQ-018 Moore FSM: state codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BRANCH=8, ADDIEXE=9, ADDIWB=10, JUMP=11.
REQ-019 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUSel=ADD, PCSrc=00, PCWrite=1 -> DECODE.
REQ-020 DECODE: ALUSrcA=0, ALUSrcB=10, ALUSel=ADD (branch target PC+1+imm into ALUOut); next state by Opcode: 100011/101011 -> MEMADR, 000000 -> RTEXE, 001000 -> ADDIEXE, 000100 -> BRANCH, 000010 -> JUMP, any other -> FETCH (treat as NOP).
REQ-021 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUSel=ADD; next MEMRD if Opcode=100011, else MEMWR.
REQ-022 MEMRD: IorD=1 -> MEMWB.  MEMWB: RegDst=0, MtoRF=1, RFWE=1 -> FETCH.
REQ-023 MEMWR: IorD=1, MWE=1 for exactly one cycle -> FETCH.
REQ-024 RTEXE: ALUSrcA=1, ALUSrcB=00, ALUSel from Funct: 100000 ADD, 100010 SUB, 000000 SLL, 000100 SLLV, 000111 SRAV, other -> ADD -> RTWB.
REQ-025 RTWB: RegDst=1, MtoRF=0, RFWE=1 -> FETCH.
REQ-026 ADDIEXE: ALUSrcA=1, ALUSrcB=10, ALUSel=ADD -> ADDIWB.  ADDIWB: RegDst=0, MtoRF=0, RFWE=1 -> FETCH.
REQ-027 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUSel=SUB, Branch=1, PCSrc=01; PCEn=Zero -> FETCH.
REQ-028 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-029 Every output not listed for a state is 0 in that state; outputs are pure functions of State (plus Zero for PCEn).
REQ-030 Instruction latency in cycles: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, unknown opcode 2.
REQ-031 Opcode/Funct are sampled only in DECODE, MEMADR and RTEXE; changes in other states have no effect.
REQ-032 Unused state codes 12-15 SHALL transition to FETCH on the next edge with all outputs 0.

Reset
REQ-033 rst=0 SHALL force State=FETCH immediately (asynchronous) and hold it while rst=0.
REQ-034 While rst=0 all outputs except State SHALL be 0 (no PC, IR, memory or register writes).
REQ-035 Reset asserted mid-instruction (e.g. in MEMWR) SHALL deassert MWE within the same cycle, with no partial write after release.
REQ-036 The first rising edge after rst returns to 1 SHALL perform a FETCH (IRWrite=1, PCEn=1).

Verification
REQ-037 LW (Opcode=100011): State 0,1,2,3,4,0; RFWE=1 only in state 4 with MtoRF=1, RegDst=0; MWE never 1.
REQ-038 SW (Opcode=101011): State 0,1,2,5,0; MWE=1 and IorD=1 for exactly one cycle in state 5.
REQ-039 R-type Funct=000111: State 0,1,6,7,0; ALUSel=0100 in state 6; RFWE=1, RegDst=1 in state 7.
REQ-040 BEQ with Zero=1 -> PCEn=1, PCSrc=01 in state 8; repeat with Zero=0 -> PCEn=0 in state 8.
REQ-041 Opcode=111111 -> State 0,1,0 with RFWE=MWE=0 throughout; J (000010) -> State 0,1,11,0 with PCSrc=10, PCEn=1 in state 11.
REQ-042 Assert rst=0 during state 5 -> MWE=0 and State=0 immediately without waiting for an edge; after release the first edge shows IRWrite=1.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle processor control unit: a Moore FSM that sequences the
// fetch/decode/execute/writeback steps of a small MIPS-like ISA
// (LW, SW, R-type, ADDI, BEQ, J).
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   Opcode   instruction[31:26] from the instruction register
//   Funct    instruction[5:0]
//   Zero     ALU zero flag
//   MWE, IorD, IRWrite, RFWE, RegDst, MtoRF, ALUSrcA, ALUSrcB, ALUSel,
//   PCSrc    datapath controls decoded from the current state
//   PCEn     PC load = PCWrite | (Branch & Zero)
//   State    current state code, for debug and verification
//
// Controls are decoded from the state register rather than registered so
// that the fetch controls are already up when reset releases. Every
// control is qualified by rst, so writes stop the moment reset asserts.
module multi_cycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       MWE,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RFWE,
  output logic       RegDst,
  output logic       MtoRF,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUSel,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned SEL_W   = 4;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] FN_SLLV = 6'b000100;
  localparam logic [OP_W-1:0] FN_SRAV = 6'b000111;

  // ALU operations
  localparam logic [SEL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [SEL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [SEL_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [SEL_W-1:0] ALU_SLLV = 4'b0011;
  localparam logic [SEL_W-1:0] ALU_SRAV = 4'b0100;

  // ALU operand B / PC source encodings
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEXE = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  // Decoded controls before reset qualification
  logic             mwe_c;
  logic             iord_c;
  logic             irwrite_c;
  logic             rfwe_c;
  logic             regdst_c;
  logic             mtorf_c;
  logic             alusrca_c;
  logic [1:0]       alusrcb_c;
  logic [SEL_W-1:0] alusel_c;
  logic [1:0]       pcsrc_c;
  logic             pcwrite_c;
  logic             branch_c;
  logic [SEL_W-1:0] rt_alusel_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // R-type ALU operation; unknown function codes fall back to ADD
  always_comb begin
    rt_alusel_c = ALU_ADD;
    case (Funct)
      FN_ADD:  rt_alusel_c = ALU_ADD;
      FN_SUB:  rt_alusel_c = ALU_SUB;
      FN_SLL:  rt_alusel_c = ALU_SLL;
      FN_SLLV: rt_alusel_c = ALU_SLLV;
      FN_SRAV: rt_alusel_c = ALU_SRAV;
      default: rt_alusel_c = ALU_ADD;
    endcase
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d   = S_FETCH;
    mwe_c     = 1'b0;
    iord_c    = 1'b0;
    irwrite_c = 1'b0;
    rfwe_c    = 1'b0;
    regdst_c  = 1'b0;
    mtorf_c   = 1'b0;
    alusrca_c = 1'b0;
    alusrcb_c = SRCB_REG;
    alusel_c  = ALU_ADD;
    pcsrc_c   = PC_ALURES;
    pcwrite_c = 1'b0;
    branch_c  = 1'b0;

    case (state_q)
      S_FETCH: begin
        irwrite_c = 1'b1;
        alusrcb_c = SRCB_ONE;
        pcwrite_c = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target PC+1+imm into ALUOut
        alusrcb_c = SRCB_IMM;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEXE;
          OP_ADDI:      state_d = S_ADDIEXE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = SRCB_IMM;
        state_d   = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_c  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mtorf_c = 1'b1;
        rfwe_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        iord_c  = 1'b1;
        mwe_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_RTEXE: begin
        alusrca_c = 1'b1;
        alusel_c  = rt_alusel_c;
        state_d   = S_RTWB;
      end
      S_RTWB: begin
        regdst_c = 1'b1;
        rfwe_c   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_c = 1'b1;
        alusel_c  = ALU_SUB;
        branch_c  = 1'b1;
        pcsrc_c   = PC_ALUOUT;
        state_d   = S_FETCH;
      end
      S_ADDIEXE: begin
        alusrca_c = 1'b1;
        alusrcb_c = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        rfwe_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_c   = PC_JUMP;
        pcwrite_c = 1'b1;
        state_d   = S_FETCH;
      end
      // Unused codes recover to FETCH with every control low
      default: state_d = S_FETCH;
    endcase
  end

  // Reset qualification: nothing writes while rst is low
  assign MWE     = rst & mwe_c;
  assign IorD    = rst & iord_c;
  assign IRWrite = rst & irwrite_c;
  assign RFWE    = rst & rfwe_c;
  assign RegDst  = rst & regdst_c;
  assign MtoRF   = rst & mtorf_c;
  assign ALUSrcA = rst & alusrca_c;
  assign ALUSrcB = {2{rst}} & alusrcb_c;
  assign ALUSel  = {SEL_W{rst}} & alusel_c;
  assign PCSrc   = {2{rst}} & pcsrc_c;
  assign PCEn    = rst & (pcwrite_c | (branch_c & Zero));
  assign State   = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control: per-instruction state sequences
// and per-state control words come from a reference model built from the
// instruction set description.
module tb_multi_cycle_control;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4,
                 MEMWR = 5, RTEXE = 6, RTWB = 7, BRANCH = 8, ADDIEXE = 9,
                 ADDIWB = 10, JUMP = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MWE, IorD, IRWrite, RFWE, RegDst, MtoRF, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUSel, State;

  int n_checks = 0;
  int n_errors = 0;
  int exp_seq[$];

  multi_cycle_control dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MWE(MWE), .IorD(IorD), .IRWrite(IRWrite), .RFWE(RFWE),
    .RegDst(RegDst), .MtoRF(MtoRF), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUSel(ALUSel), .PCSrc(PCSrc), .PCEn(PCEn), .State(State)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Control word layout: MWE IorD IRWrite RFWE RegDst MtoRF ALUSrcA
  // ALUSrcB[2] ALUSel[4] PCSrc[2] PCEn
  function automatic logic [15:0] observed();
    return {MWE, IorD, IRWrite, RFWE, RegDst, MtoRF, ALUSrcA,
            ALUSrcB, ALUSel, PCSrc, PCEn};
  endfunction

  function automatic logic [3:0] rt_op(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'd1;
      6'b000000: return 4'd2;
      6'b000100: return 4'd3;
      6'b000111: return 4'd4;
      default:   return 4'd0;
    endcase
  endfunction

  // Expected controls for a state, listed field by field from the ISA table
  function automatic logic [15:0] model_ctrl(input int st, input logic [5:0] fn, input logic z);
    logic mwe = 0, iord = 0, irw = 0, rfwe = 0, rdst = 0, m2r = 0, sa = 0;
    logic [1:0] sb = 0, pcs = 0;
    logic [3:0] op = 0;
    logic pcw = 0, br = 0;
    if (st == FETCH)   begin irw = 1; sb = 2'b01; pcw = 1; end
    if (st == DECODE)  sb = 2'b10;
    if (st == MEMADR || st == ADDIEXE) begin sa = 1; sb = 2'b10; end
    if (st == MEMRD)   iord = 1;
    if (st == MEMWB)   begin m2r = 1; rfwe = 1; end
    if (st == MEMWR)   begin iord = 1; mwe = 1; end
    if (st == RTEXE)   begin sa = 1; op = rt_op(fn); end
    if (st == RTWB)    begin rdst = 1; rfwe = 1; end
    if (st == ADDIWB)  rfwe = 1;
    if (st == BRANCH)  begin sa = 1; op = 4'd1; br = 1; pcs = 2'b01; end
    if (st == JUMP)    begin pcs = 2'b10; pcw = 1; end
    return {mwe, iord, irw, rfwe, rdst, m2r, sa, sb, op, pcs, pcw | (br & z)};
  endfunction

  // Expected state walk of one instruction, starting at FETCH
  task automatic build_seq(input logic [5:0] op);
    exp_seq = {FETCH, DECODE};
    case (op)
      6'b100011: exp_seq = {exp_seq, MEMADR, MEMRD, MEMWB};
      6'b101011: exp_seq = {exp_seq, MEMADR, MEMWR};
      6'b000000: exp_seq = {exp_seq, RTEXE, RTWB};
      6'b001000: exp_seq = {exp_seq, ADDIEXE, ADDIWB};
      6'b000100: exp_seq = {exp_seq, BRANCH};
      6'b000010: exp_seq = {exp_seq, JUMP};
      default:   ;
    endcase
  endtask

  // Called ~1ns after the edge that entered FETCH. zmode: 0/1 force Zero,
  // 2 random. abort_at >= 0 asserts reset after checking that step.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int abort_at);
    int st;
    build_seq(op);
    for (int i = 0; i < exp_seq.size(); i++) begin
      st = exp_seq[i];
      if (st == DECODE || st == MEMADR || st == RTEXE) begin
        Opcode = op;
        Funct  = fn;
      end else begin
        Opcode = 6'($urandom);
        Funct  = 6'($urandom);
      end
      Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      check($sformatf("state op=%b step=%0d", op, i), 32'(State), 32'(st));
      check($sformatf("ctrl op=%b st=%0d", op, st), 32'(observed()),
            32'(model_ctrl(st, Funct, Zero)));
      if (i == abort_at) begin
        #1 rst = 1'b0;
        #1;
        check("async reset state", 32'(State), 32'(FETCH));
        check("async reset ctrl", 32'(observed()), 32'd0);
        @(posedge clk); #1;
        check("held reset state", 32'(State), 32'(FETCH));
        check("held reset ctrl", 32'(observed()), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b000000, 6'b000100, 6'b000111};

    rst = 1'b0; Opcode = 6'b100011; Funct = 6'd0; Zero = 1'b1;
    #2;
    check("reset state", 32'(State), 32'(FETCH));
    check("reset ctrl", 32'(observed()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset held ctrl", 32'(observed()), 32'd0);
    rst = 1'b1;

    // Directed walk through each instruction class
    run_instr(6'b100011, 6'd0,      2, -1);
    run_instr(6'b101011, 6'd0,      2, -1);
    run_instr(6'b000000, 6'b000111, 2, -1);
    run_instr(6'b000100, 6'd0,      1, -1);
    run_instr(6'b000100, 6'd0,      0, -1);
    run_instr(6'b111111, 6'd0,      2, -1);
    run_instr(6'b000010, 6'd0,      2, -1);
    run_instr(6'b000000, 6'b101010, 2, -1);
    // Reset during the SW write cycle, then resume
    run_instr(6'b101011, 6'd0,      2, 3);
    run_instr(6'b001000, 6'd0,      2, -1);

    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 6'($urandom);
      fn = ($urandom_range(0, 5) < 5) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(op, fn, 2, (n % 37 == 5) ? int'($urandom_range(0, 2)) : -1);
    end

    @(negedge clk);
    check("final state", 32'(State), 32'(FETCH));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
